fb_swap_controller: RTL and testbench
=====================================

Name: fb_swap_controller

Overview:
- Parametrised successor to the fixed double-buffer framebuffer controller. Owns N framebuffer roles (display, ready, draw) and swaps them on the display vsync.
- Clears each buffer before handing it to the sprite driver for drawing.
- Sits between sprite_driver (frame_done, draw buffer select), screen_driver (display buffer select) and the framebuffer BRAMs (clear write port).
- Supports double (2) and triple (3) buffering, with dropped-frame accounting.

Parameters:
- NUM_BUFFERS, 3, number of framebuffers; legal values are 2 or 3 only.
- ADDR_WIDTH, 19, framebuffer address width.
- DATA_WIDTH, 4, colour index width.
- FB_PIXELS, 307200, number of addresses cleared per buffer.
- CLEAR_COLOR, 0, colour index written during a clear.
- CLEAR_ENABLE, 1, when 0 no sweep is performed and a new draw buffer is ready immediately.

Ports:
- clock  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  display vsync, same clock domain; the rising edge is the swap point.
- frame_done  in  1  one-cycle pulse: the draw buffer is complete.
- draw_buf  out  BW  index of the buffer the sprite driver writes; BW = max(1, $clog2(NUM_BUFFERS)).
- draw_ready  out  1  draw_buf is cleared and owned by the writer.
- display_buf  out  BW  index of the buffer scanned out by the screen drivers.
- clear_buf  out  BW  buffer targeted by the clear sweep.
- clear_addr  out  ADDR_WIDTH  clear write address.
- clear_data  out  DATA_WIDTH  always CLEAR_COLOR.
- clear_en  out  1  clear write strobe.
- init_busy  out  1  power-up clear of all buffers in progress.
- swap  out  1  one-cycle pulse when display_buf changes.
- drop_count  out  16  saturating count of frames discarded.

Behaviour:
- Reset values (async on reset_n low):
  - display_buf=0, draw_buf=1, ready slot empty.
  - clear_buf=0, clear_addr=0, clear_en=0.
  - draw_ready=0, init_busy=1, swap=0, drop_count=0.
  - Reset mid-sweep aborts the sweep and restarts INIT.
- States:
  - INIT: sweeps buffers 0..NUM_BUFFERS-1 in order, one address per cycle. Total length NUM_BUFFERS*FB_PIXELS cycles of clear_en=1, then goes to DRAW. init_busy deasserts the cycle DRAW is entered.
  - CLEAR: sweeps draw_buf for addresses 0..FB_PIXELS-1, with clear_buf=draw_buf. At the last address it goes to DRAW.
  - DRAW: draw_ready=1.
  - WAIT_SWAP: used only when NUM_BUFFERS=2; draw_ready=0.
- Clear sweep:
  - clear_addr increments by 1 per cycle while clear_en=1 and wraps to 0 at the end of each buffer.
  - With CLEAR_ENABLE=0, INIT and CLEAR last 0 cycles and clear_en is never asserted.
- vsync edge:
  - Detected as vsync=1 with the registered previous value=0.
  - Response is registered: display_buf and swap update on the cycle after the edge sample.
- Triple buffering (NUM_BUFFERS=3), frame_done in DRAW:
  - Ready slot empty: ready=draw_buf; draw_buf=the free buffer; go to CLEAR.
  - Ready slot occupied: the old ready buffer becomes draw_buf; ready=old draw_buf; drop_count++; go to CLEAR.
- Triple buffering, vsync edge with ready occupied:
  - display_buf=ready, ready slot empty, old display becomes free, swap=1.
  - Allowed in any state except INIT.
  - With ready empty: no change and swap=0.
- Double buffering (NUM_BUFFERS=2):
  - frame_done in DRAW: ready=draw_buf; go to WAIT_SWAP.
  - vsync edge in WAIT_SWAP: display_buf=ready, draw_buf=old display, swap=1; go to CLEAR.
- frame_done while draw_ready=0 (INIT, CLEAR, WAIT_SWAP) is ignored and not counted.
- frame_done and a vsync edge in the same cycle: frame_done is applied first, so the just-finished frame is displayed by that swap. This means a triple-buffer swap pulse with no drop.
- Invariant: display_buf, draw_buf and ready (if occupied) are pairwise distinct at all times.
- drop_count saturates at 16'hFFFF.

Test Plan:
1. NUM_BUFFERS=3, FB_PIXELS=16, release reset → clear_en high exactly 48 cycles; clear_buf goes 0,1,2; then init_busy=0, draw_ready=1, draw_buf=1, display_buf=0.
2. Triple: frame_done, then vsync edge → draw_buf=2 plus 16 clear cycles; the cycle after the edge, display_buf=1 and swap=1 for one cycle; drop_count=0.
3. Triple: two frame_done pulses with no vsync (wait for draw_ready between them) → drop_count=1; next vsync displays the second frame's buffer, never the first.
4. NUM_BUFFERS=2: frame_done → draw_ready=0 until vsync; after the edge, display_buf=1, draw_buf=0, 16 clear cycles on buffer 0, then draw_ready=1; a frame_done during WAIT_SWAP is ignored.
5. Triple: frame_done coincident with the vsync edge → display_buf becomes the just-finished buffer the next cycle; drop_count unchanged.
6. reset_n low at clear_addr=7 during CLEAR → all outputs immediately at reset values; on release, INIT restarts from buffer 0, addr 0; CLEAR_ENABLE=0 variant gives draw_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/fb_swap_controller.sv
// -----------------------------------------------------------------------------
// fb_swap_controller
//
// Owns the roles of NUM_BUFFERS framebuffers (display, ready, draw) and
// rotates them on the rising edge of the display vsync. Every buffer is cleared
// before it is handed to the sprite driver, and frames the display never got
// to show are counted in drop_count.
//
// NUM_BUFFERS must be 2 (double buffering) or 3 (triple buffering).
//
// Ports:
//   clock        pixel clock
//   reset_n      asynchronous, active-low reset
//   vsync        display vsync (same clock domain); rising edge is the swap point
//   frame_done   one-cycle pulse from the sprite driver: draw buffer complete
//   draw_buf     buffer the sprite driver writes
//   draw_ready   draw_buf is cleared and owned by the sprite driver
//   display_buf  buffer scanned out by the screen driver
//   clear_buf    buffer targeted by the clear sweep
//   clear_addr   clear write address
//   clear_data   clear write data (always CLEAR_COLOR)
//   clear_en     clear write strobe
//   init_busy    power-up clear of all buffers in progress
//   swap         one-cycle pulse when display_buf changes
//   drop_count   saturating count of discarded frames
// -----------------------------------------------------------------------------
module fb_swap_controller #(
  parameter int NUM_BUFFERS  = 3,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 4,
  parameter int FB_PIXELS    = 307200,
  parameter int CLEAR_COLOR  = 0,
  parameter bit CLEAR_ENABLE = 1'b1,
  localparam int BW = (NUM_BUFFERS <= 2) ? 1 : $clog2(NUM_BUFFERS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  vsync,
  input  logic                  frame_done,
  output logic [BW-1:0]         draw_buf,
  output logic                  draw_ready,
  output logic [BW-1:0]         display_buf,
  output logic [BW-1:0]         clear_buf,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic [DATA_WIDTH-1:0] clear_data,
  output logic                  clear_en,
  output logic                  init_busy,
  output logic                  swap,
  output logic [15:0]           drop_count
);

  localparam bit                  TRIPLE    = (NUM_BUFFERS == 3);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - 1);
  localparam logic [BW-1:0]       LAST_BUF  = BW'(NUM_BUFFERS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_CLEAR,
    S_DRAW,
    S_WAIT_SWAP
  } state_t;

  state_t        state;
  logic [BW-1:0] ready_buf;
  logic          ready_valid;
  logic          vsync_q;

  // Intermediate view after frame_done has been applied. A vsync edge in the
  // same cycle works from this view, so the frame that just finished is the
  // one the swap puts on screen.
  logic          fd_accept;
  logic          fd_drop;
  logic [BW-1:0] fd_draw;
  logic [BW-1:0] fd_ready;
  logic          fd_ready_valid;
  state_t        fd_state;
  logic [BW-1:0] free_buf;
  logic          vsync_edge;
  logic          do_swap;

  assign clear_data = DATA_WIDTH'(CLEAR_COLOR);
  assign vsync_edge = vsync & ~vsync_q;

  // With three buffers and the ready slot empty, the indices in use are
  // display and draw; the remaining one is 0+1+2 minus both of them.
  always_comb begin
    free_buf = BW'(3 - int'(display_buf) - int'(draw_buf));
  end

  // frame_done is honoured only while the writer owns a cleared buffer,
  // which is exactly the DRAW state.
  always_comb begin
    fd_accept      = frame_done && (state == S_DRAW);
    fd_drop        = 1'b0;
    fd_draw        = draw_buf;
    fd_ready       = ready_buf;
    fd_ready_valid = ready_valid;
    fd_state       = state;
    if (fd_accept) begin
      fd_ready       = draw_buf;
      fd_ready_valid = 1'b1;
      if (TRIPLE) begin
        fd_state = S_CLEAR;
        if (ready_valid) begin
          // The frame waiting in the ready slot was never shown; recycle it
          // as the next draw buffer.
          fd_draw = ready_buf;
          fd_drop = 1'b1;
        end else begin
          fd_draw = free_buf;
        end
      end else begin
        fd_state = S_WAIT_SWAP;
      end
    end
  end

  always_comb begin
    do_swap = vsync_edge && (state != S_INIT) && fd_ready_valid &&
              (TRIPLE || (fd_state == S_WAIT_SWAP));
  end

  // Single state register for roles, sweep and status outputs. Swap handling
  // comes last so it overrides the frame_done updates it depends on.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_INIT;
      display_buf <= BW'(0);
      draw_buf    <= BW'(1);
      ready_buf   <= BW'(0);
      ready_valid <= 1'b0;
      clear_buf   <= BW'(0);
      clear_addr  <= '0;
      clear_en    <= 1'b0;
      draw_ready  <= 1'b0;
      init_busy   <= 1'b1;
      swap        <= 1'b0;
      drop_count  <= 16'd0;
      vsync_q     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      swap    <= 1'b0;

      case (state)
        S_INIT: begin
          if (!CLEAR_ENABLE) begin
            state      <= S_DRAW;
            init_busy  <= 1'b0;
            draw_ready <= 1'b1;
          end else if (!clear_en) begin
            // First cycle out of reset: start the sweep at buffer 0.
            clear_en   <= 1'b1;
            clear_buf  <= BW'(0);
            clear_addr <= '0;
          end else if (clear_addr == LAST_ADDR) begin
            clear_addr <= '0;
            if (clear_buf == LAST_BUF) begin
              clear_en   <= 1'b0;
              state      <= S_DRAW;
              init_busy  <= 1'b0;
              draw_ready <= 1'b1;
            end else begin
              clear_buf <= clear_buf + BW'(1);
            end
          end else begin
            clear_addr <= clear_addr + ADDR_WIDTH'(1);
          end
        end

        S_CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            clear_en   <= 1'b0;
            clear_addr <= '0;
            state      <= S_DRAW;
            draw_ready <= 1'b1;
          end else begin
            clear_addr <= clear_addr + ADDR_WIDTH'(1);
          end
        end

        default: begin
        end
      endcase

      if (fd_accept) begin
        draw_buf    <= fd_draw;
        ready_buf   <= fd_ready;
        ready_valid <= fd_ready_valid;
        if (fd_drop && (drop_count != 16'hFFFF)) begin
          drop_count <= drop_count + 16'd1;
        end
        if (TRIPLE) begin
          if (CLEAR_ENABLE) begin
            state      <= S_CLEAR;
            clear_en   <= 1'b1;
            clear_addr <= '0;
            clear_buf  <= fd_draw;
            draw_ready <= 1'b0;
          end
        end else begin
          state      <= S_WAIT_SWAP;
          draw_ready <= 1'b0;
        end
      end

      if (do_swap) begin
        display_buf <= fd_ready;
        ready_valid <= 1'b0;
        swap        <= 1'b1;
        if (!TRIPLE) begin
          // Double buffering: the old display buffer becomes the next draw
          // buffer and must be cleared first.
          draw_buf <= display_buf;
          if (CLEAR_ENABLE) begin
            state      <= S_CLEAR;
            clear_en   <= 1'b1;
            clear_addr <= '0;
            clear_buf  <= display_buf;
            draw_ready <= 1'b0;
          end else begin
            state      <= S_DRAW;
            draw_ready <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_controller.sv
// -----------------------------------------------------------------------------
// tb_fb_swap_controller
//
// Three instances share one clock: a triple-buffered controller, a
// double-buffered one and a triple-buffered one without clearing. Each swap
// pulse is checked against an expectation queued when the vsync was issued.
// -----------------------------------------------------------------------------
module tb_fb_swap_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Triple-buffered instance
  logic        rst3, vs3, fd3;
  logic [1:0]  draw3, disp3, cbuf3;
  logic        dr3, cen3, busy3, sw3;
  logic [18:0] caddr3;
  logic [3:0]  cdata3;
  logic [15:0] drop3;

  // Double-buffered instance
  logic        rst2, vs2, fd2;
  logic [0:0]  draw2, disp2, cbuf2;
  logic        dr2, cen2, busy2, sw2;
  logic [18:0] caddr2;
  logic [3:0]  cdata2;
  logic [15:0] drop2;

  // Triple-buffered instance with clearing disabled
  logic        rst0, vs0, fd0;
  logic [1:0]  draw0, disp0, cbuf0;
  logic        dr0, cen0, busy0, sw0;
  logic [18:0] caddr0;
  logic [3:0]  cdata0;
  logic [15:0] drop0;

  fb_swap_controller #(.NUM_BUFFERS(3), .FB_PIXELS(16)) u_dut3 (
    .clock(clock), .reset_n(rst3), .vsync(vs3), .frame_done(fd3),
    .draw_buf(draw3), .draw_ready(dr3), .display_buf(disp3),
    .clear_buf(cbuf3), .clear_addr(caddr3), .clear_data(cdata3),
    .clear_en(cen3), .init_busy(busy3), .swap(sw3), .drop_count(drop3)
  );

  fb_swap_controller #(.NUM_BUFFERS(2), .FB_PIXELS(16)) u_dut2 (
    .clock(clock), .reset_n(rst2), .vsync(vs2), .frame_done(fd2),
    .draw_buf(draw2), .draw_ready(dr2), .display_buf(disp2),
    .clear_buf(cbuf2), .clear_addr(caddr2), .clear_data(cdata2),
    .clear_en(cen2), .init_busy(busy2), .swap(sw2), .drop_count(drop2)
  );

  fb_swap_controller #(.NUM_BUFFERS(3), .FB_PIXELS(16), .CLEAR_ENABLE(1'b0)) u_dut0 (
    .clock(clock), .reset_n(rst0), .vsync(vs0), .frame_done(fd0),
    .draw_buf(draw0), .draw_ready(dr0), .display_buf(disp0),
    .clear_buf(cbuf0), .clear_addr(caddr0), .clear_data(cdata0),
    .clear_en(cen0), .init_busy(busy0), .swap(sw0), .drop_count(drop0)
  );

  typedef struct {
    int disp;
    int drop;
  } exp_t;

  exp_t exp3[$];
  exp_t exp2[$];

  int checks = 0;
  int passes = 0;

  // Clear-strobe bookkeeping, restarted whenever the instance is in reset
  int clr_cnt3, first_addr3, first_buf3, last_buf3;
  int seq3[$];
  int clr_cnt2, last_buf2;
  int clr_cnt0;

  always @(negedge clock or negedge rst3) begin
    if (!rst3) begin
      clr_cnt3    <= 0;
      first_addr3 <= -1;
      first_buf3  <= -1;
      seq3.delete();
    end else if (cen3) begin
      if (clr_cnt3 == 0) begin
        first_addr3 <= int'(caddr3);
        first_buf3  <= int'(cbuf3);
      end
      if (seq3.size() == 0 || seq3[$] != int'(cbuf3)) seq3.push_back(int'(cbuf3));
      last_buf3 <= int'(cbuf3);
      clr_cnt3  <= clr_cnt3 + 1;
    end
  end

  always @(negedge clock or negedge rst2) begin
    if (!rst2) begin
      clr_cnt2 <= 0;
    end else if (cen2) begin
      last_buf2 <= int'(cbuf2);
      clr_cnt2  <= clr_cnt2 + 1;
    end
  end

  always @(negedge clock or negedge rst0) begin
    if (!rst0) begin
      clr_cnt0 <= 0;
    end else if (cen0) begin
      clr_cnt0 <= clr_cnt0 + 1;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs of one instance just after a rising edge.
  task automatic apply_stimulus(input int dut, input logic fd, input logic vs);
    @(posedge clock);
    #1;
    case (dut)
      3:       begin fd3 = fd; vs3 = vs; end
      2:       begin fd2 = fd; vs2 = vs; end
      default: begin fd0 = fd; vs0 = vs; end
    endcase
  endtask

  task automatic expect_swap(input int dut, input int disp, input int drop);
    exp_t e;
    e.disp = disp;
    e.drop = drop;
    if (dut == 3) exp3.push_back(e);
    else          exp2.push_back(e);
  endtask

  task automatic check_reset3();
    check_output("rst_display_buf", int'(disp3), 0);
    check_output("rst_draw_buf", int'(draw3), 1);
    check_output("rst_clear_buf", int'(cbuf3), 0);
    check_output("rst_clear_addr", int'(caddr3), 0);
    check_output("rst_clear_en", int'(cen3), 0);
    check_output("rst_draw_ready", int'(dr3), 0);
    check_output("rst_init_busy", int'(busy3), 1);
    check_output("rst_swap", int'(sw3), 0);
    check_output("rst_drop_count", int'(drop3), 0);
    check_output("rst_clear_data", int'(cdata3), 0);
  endtask

  task automatic wait_ready3(input string name);
    int n = 0;
    while (!dr3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_output(name, int'(dr3), 1);
  endtask

  task automatic wait_init3(input string name);
    int n = 0;
    while (busy3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_output(name, int'(busy3), 0);
  endtask

  initial begin
    int base;
    int n;
    exp_t e;

    rst3 = 1'b0; vs3 = 1'b0; fd3 = 1'b0;
    rst2 = 1'b0; vs2 = 1'b0; fd2 = 1'b0;
    rst0 = 1'b0; vs0 = 1'b0; fd0 = 1'b0;

    // Scoreboard monitor: every swap pulse consumes one queued expectation.
    fork
      forever begin
        @(negedge clock);
        if (sw3) begin
          if (exp3.size() == 0) begin
            check_output("swap3_unexpected", int'(sw3), 0);
          end else begin
            e = exp3.pop_front();
            check_output("swap3_display_buf", int'(disp3), e.disp);
            check_output("swap3_drop_count", int'(drop3), e.drop);
          end
        end
        if (sw2) begin
          if (exp2.size() == 0) begin
            check_output("swap2_unexpected", int'(sw2), 0);
          end else begin
            e = exp2.pop_front();
            check_output("swap2_display_buf", int'(disp2), e.disp);
            check_output("swap2_drop_count", int'(drop2), e.drop);
          end
        end
      end
    join_none

    @(negedge clock);
    @(negedge clock);
    check_reset3();

    // Power-up sweep of three buffers; a vsync during INIT must not swap.
    $display("[TB] triple: power-up clear");
    apply_stimulus(3, 1'b0, 1'b0);
    rst3 = 1'b1;
    apply_stimulus(3, 1'b0, 1'b1);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_init3("init_done");
    check_output("init_clear_cycles", clr_cnt3, 48);
    check_output("init_seq_len", seq3.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_output("init_seq_buf", (seq3.size() > i) ? seq3[i] : -1, i);
    end
    check_output("init_draw_ready", int'(dr3), 1);
    check_output("init_draw_buf", int'(draw3), 1);
    check_output("init_display_buf", int'(disp3), 0);

    // frame_done then vsync: buffer 1 goes to display, buffer 2 is cleared.
    $display("[TB] triple: frame then swap");
    base = clr_cnt3;
    apply_stimulus(3, 1'b1, 1'b0);
    apply_stimulus(3, 1'b0, 1'b0);
    expect_swap(3, 1, 0);
    apply_stimulus(3, 1'b0, 1'b1);
    apply_stimulus(3, 1'b0, 1'b1);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_ready3("t2_ready");
    check_output("t2_clear_cycles", clr_cnt3 - base, 16);
    check_output("t2_clear_buf", last_buf3, 2);
    check_output("t2_draw_buf", int'(draw3), 2);

    // Two frames without a vsync: the first one (buffer 2) is dropped.
    $display("[TB] triple: dropped frame");
    apply_stimulus(3, 1'b1, 1'b0);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_ready3("t3_ready_a");
    check_output("t3_draw_buf_a", int'(draw3), 0);
    apply_stimulus(3, 1'b1, 1'b0);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_ready3("t3_ready_b");
    check_output("t3_drop_count", int'(drop3), 1);
    check_output("t3_draw_buf_b", int'(draw3), 2);
    expect_swap(3, 0, 1);
    apply_stimulus(3, 1'b0, 1'b1);
    apply_stimulus(3, 1'b0, 1'b1);
    apply_stimulus(3, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);

    // frame_done coincident with the vsync edge: the fresh frame is shown.
    $display("[TB] triple: coincident frame_done and vsync");
    expect_swap(3, 2, 1);
    apply_stimulus(3, 1'b1, 1'b1);
    apply_stimulus(3, 1'b0, 1'b1);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_ready3("t5_ready");
    check_output("t5_draw_buf", int'(draw3), 1);
    check_output("t5_drop_count", int'(drop3), 1);

    // Reset in the middle of a clear sweep, then a full INIT restart.
    $display("[TB] triple: reset mid-clear");
    apply_stimulus(3, 1'b1, 1'b0);
    apply_stimulus(3, 1'b0, 1'b0);
    n = 0;
    while (!(cen3 && caddr3 == 19'd7) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output("t6_reached_addr7", int'(caddr3), 7);
    rst3 = 1'b0;
    #1;
    check_reset3();
    apply_stimulus(3, 1'b0, 1'b0);
    rst3 = 1'b1;
    wait_init3("t6_init_done");
    check_output("t6_first_addr", first_addr3, 0);
    check_output("t6_first_buf", first_buf3, 0);
    check_output("t6_clear_cycles", clr_cnt3, 48);
    check_output("t6_draw_buf", int'(draw3), 1);
    check_output("t6_display_buf", int'(disp3), 0);

    // Double buffering.
    $display("[TB] double: frame, ignored frame, swap");
    apply_stimulus(2, 1'b0, 1'b0);
    rst2 = 1'b1;
    n = 0;
    while (busy2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_output("d_init_clear_cycles", clr_cnt2, 32);
    check_output("d_init_draw_ready", int'(dr2), 1);
    apply_stimulus(2, 1'b1, 1'b0);
    apply_stimulus(2, 1'b0, 1'b0);
    base = clr_cnt2;
    repeat (5) @(negedge clock);
    check_output("d_wait_draw_ready", int'(dr2), 0);
    apply_stimulus(2, 1'b1, 1'b0);
    apply_stimulus(2, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check_output("d_wait_no_clear", clr_cnt2 - base, 0);
    check_output("d_wait_draw_ready_b", int'(dr2), 0);
    check_output("d_wait_drop_count", int'(drop2), 0);
    expect_swap(2, 1, 0);
    apply_stimulus(2, 1'b0, 1'b1);
    apply_stimulus(2, 1'b0, 1'b1);
    apply_stimulus(2, 1'b0, 1'b0);
    n = 0;
    while (!dr2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_output("d_ready_after_clear", int'(dr2), 1);
    check_output("d_clear_cycles", clr_cnt2 - base, 16);
    check_output("d_clear_buf", last_buf2, 0);
    check_output("d_draw_buf", int'(draw2), 0);
    check_output("d_display_buf", int'(disp2), 1);

    // No clearing: draw_ready one cycle after reset release.
    $display("[TB] no-clear variant");
    apply_stimulus(0, 1'b0, 1'b0);
    rst0 = 1'b1;
    @(negedge clock);
    check_output("nc_not_ready_yet", int'(dr0), 0);
    @(negedge clock);
    check_output("nc_draw_ready", int'(dr0), 1);
    check_output("nc_init_busy", int'(busy0), 0);
    apply_stimulus(0, 1'b1, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0);
    @(negedge clock);
    check_output("nc_draw_buf", int'(draw0), 2);
    check_output("nc_ready_kept", int'(dr0), 1);
    apply_stimulus(0, 1'b1, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0);
    @(negedge clock);
    check_output("nc_drop_count", int'(drop0), 1);
    check_output("nc_draw_buf_b", int'(draw0), 1);
    check_output("nc_no_clear", clr_cnt0, 0);

    repeat (4) @(negedge clock);
    check_output("exp3_drained", exp3.size(), 0);
    check_output("exp2_drained", exp2.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
